// File: rtl/ps2_pkg.sv
// PS/2 mouse init: shared command/response bytes, FSM state and error encodings.
package ps2_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_ERROR    = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_ID_MOUSE = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ISSUE, ST_WAIT_TX, ST_WAIT_ACK,
        ST_WAIT_BAT, ST_WAIT_ID, ST_READY, ST_FAIL
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE, ERR_TIMEOUT, ERR_DEVICE, ERR_UNEXP
    } err_t;

    // command ROM: reset, set-rate, rate byte, enable streaming
    function automatic logic [7:0] step_cmd(input logic [1:0] step, input logic [7:0] rate);
        case (step)
            2'd0:    step_cmd = CMD_RESET;
            2'd1:    step_cmd = CMD_SET_RATE;
            2'd2:    step_cmd = rate;
            default: step_cmd = CMD_ENABLE;
        endcase
    endfunction

endpackage

// File: rtl/ps2_timeout_ctr.sv
// Loadable saturating down-counter; oTC flags zero while no load is pending.
module ps2_timeout_ctr #(
    parameter int W = 8
) (
    input  logic         iCLK_50,
    input  logic         iRST,
    input  logic         iLOAD,
    input  logic [W-1:0] iLOAD_VAL,
    output logic         oTC
);

    logic [W-1:0] cnt;

    // reload on request, otherwise count down and park at zero
    always_ff @(posedge iCLK_50) begin
        if (iRST)
            cnt <= '0;
        else if (iLOAD)
            cnt <= iLOAD_VAL;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign oTC = (cnt == '0) && !iLOAD;

endmodule

// File: rtl/ps2_mouse_init_seq.sv
// PS/2 mouse power-up sequencer: FF/AA/00, F3+rate, F4 with resend, timeout and retry handling.
module ps2_mouse_init_seq
    import ps2_pkg::*;
#(
    parameter logic [7:0] SAMPLE_RATE = 8'd100,
    parameter int         ACK_TO_CYC  = 1_000_000,
    parameter int         BAT_TO_CYC  = 50_000_000,
    parameter int         MAX_RETRY   = 3
) (
    input  logic       iCLK_50,
    input  logic       iRST,
    input  logic       iSTART,
    input  logic       iTX_RDY,
    output logic       oTX_REQ,
    output logic [7:0] oTX_DATA,
    input  logic       iTX_DONE,
    input  logic       iTX_ERR,
    input  logic       iRX_VALID,
    input  logic [7:0] iRX_DATA,
    output logic       oREADY,
    output logic       oFAIL,
    output logic [1:0] oERR_CODE,
    output logic [1:0] oRETRY_CNT,
    output logic [2:0] oSTEP
);

    localparam int TO_MAX = (ACK_TO_CYC > BAT_TO_CYC) ? ACK_TO_CYC : BAT_TO_CYC;
    localparam int TW     = (TO_MAX > 2) ? $clog2(TO_MAX) : 1;
    // the load lands one cycle after entry, so load N-2 to expire on the N-th cycle in the state
    localparam logic [TW-1:0] ACK_LD = TW'((ACK_TO_CYC >= 2) ? ACK_TO_CYC - 2 : 0);
    localparam logic [TW-1:0] BAT_LD = TW'((BAT_TO_CYC >= 2) ? BAT_TO_CYC - 2 : 0);
    localparam logic [2:0]    MAX_R  = 3'(MAX_RETRY);

    state_t        state;
    logic [1:0]    step, retry, resend;
    logic          tmr_ld, tmr_tc;
    logic [TW-1:0] tmr_val;
    logic          ack_rx, resend_last, tx_err, fail_now;
    err_t          fail_code;

    ps2_timeout_ctr #(.W(TW)) u_tmr (
        .iCLK_50   (iCLK_50),
        .iRST      (iRST),
        .iLOAD     (tmr_ld),
        .iLOAD_VAL (tmr_val),
        .oTC       (tmr_tc)
    );

    // classify this cycle's event: byte needing ACK evaluation, TX error, or a restart cause
    always_comb begin
        ack_rx      = iRX_VALID && ((state == ST_WAIT_ACK) || (state == ST_WAIT_TX && iTX_DONE));
        tx_err      = (state == ST_WAIT_TX) && iTX_ERR && !iTX_DONE;
        resend_last = ({1'b0, resend} + 3'd1) >= MAX_R;
        fail_now    = 1'b0;
        fail_code   = ERR_NONE;
        if (ack_rx) begin
            case (iRX_DATA)
                RSP_ACK:    fail_now = 1'b0;
                RSP_RESEND: begin fail_now = resend_last; fail_code = ERR_UNEXP;  end
                RSP_ERROR:  begin fail_now = 1'b1;        fail_code = ERR_DEVICE; end
                default:    begin fail_now = 1'b1;        fail_code = ERR_UNEXP;  end
            endcase
        end else if (tx_err) begin
            fail_now  = resend_last;
            fail_code = ERR_UNEXP;
        end else if (state == ST_WAIT_ACK || state == ST_WAIT_BAT || state == ST_WAIT_ID) begin
            if (iRX_VALID) begin
                if (iRX_DATA == RSP_ERROR) begin
                    fail_now  = 1'b1;
                    fail_code = ERR_DEVICE;
                end else if (!((state == ST_WAIT_BAT && iRX_DATA == RSP_BAT_OK) ||
                               (state == ST_WAIT_ID  && iRX_DATA == RSP_ID_MOUSE))) begin
                    fail_now  = 1'b1;
                    fail_code = ERR_UNEXP;
                end
            end else if (tmr_tc) begin
                fail_now  = 1'b1;
                fail_code = ERR_TIMEOUT;
            end
        end
    end

    // sequencer FSM: reset > start > restart path > ACK/resend > per-state progress
    always_ff @(posedge iCLK_50) begin
        oTX_REQ <= 1'b0;
        tmr_ld  <= 1'b0;
        if (iRST) begin
            state     <= ST_IDLE;
            step      <= 2'd0;
            retry     <= 2'd0;
            resend    <= 2'd0;
            oTX_DATA  <= 8'h00;
            oREADY    <= 1'b0;
            oFAIL     <= 1'b0;
            oERR_CODE <= ERR_NONE;
            tmr_val   <= '0;
        end else if (iSTART) begin
            state     <= ST_ISSUE;
            step      <= 2'd0;
            retry     <= 2'd0;
            resend    <= 2'd0;
            oREADY    <= 1'b0;
            oFAIL     <= 1'b0;
            oERR_CODE <= ERR_NONE;
        end else if (fail_now) begin
            oERR_CODE <= fail_code;
            step      <= 2'd0;
            resend    <= 2'd0;
            if ({1'b0, retry} < MAX_R) begin
                retry <= retry + 2'd1;
                state <= ST_ISSUE;
            end else begin
                state  <= ST_FAIL;
                oFAIL  <= 1'b1;
                oREADY <= 1'b0;
            end
        end else if (ack_rx && iRX_DATA == RSP_ACK) begin
            resend <= 2'd0;
            case (step)
                2'd0: begin
                    state   <= ST_WAIT_BAT;
                    tmr_ld  <= 1'b1;
                    tmr_val <= BAT_LD;
                end
                2'd3: begin
                    state  <= ST_READY;
                    oREADY <= 1'b1;
                end
                default: begin
                    step  <= step + 2'd1;
                    state <= ST_ISSUE;
                end
            endcase
        end else if (ack_rx || tx_err) begin
            // only a non-exhausting FE or line error reaches here: resend same step
            resend <= resend + 2'd1;
            state  <= ST_ISSUE;
        end else begin
            case (state)
                ST_ISSUE: if (iTX_RDY) begin
                    oTX_REQ  <= 1'b1;
                    oTX_DATA <= step_cmd(step, SAMPLE_RATE);
                    state    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: if (iTX_DONE) begin
                    state   <= ST_WAIT_ACK;
                    tmr_ld  <= 1'b1;
                    tmr_val <= ACK_LD;
                end
                ST_WAIT_BAT: if (iRX_VALID) begin
                    state   <= ST_WAIT_ID;
                    tmr_ld  <= 1'b1;
                    tmr_val <= BAT_LD;
                end
                ST_WAIT_ID: if (iRX_VALID) begin
                    state <= ST_ISSUE;
                    step  <= 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign oRETRY_CNT = retry;
    assign oSTEP      = {1'b0, step};

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Bench: byte-level link/device model; expected TX bytes queued per scenario and checked on each oTX_REQ.
module tb_ps2_mouse_init_seq;

    logic       iCLK_50 = 1'b0;
    logic       iRST = 1'b1, iSTART = 1'b0, iTX_RDY = 1'b0;
    logic       iTX_DONE = 1'b0, iTX_ERR = 1'b0, iRX_VALID = 1'b0;
    logic [7:0] iRX_DATA = 8'h00;
    logic       oTX_REQ, oREADY, oFAIL;
    logic [7:0] oTX_DATA;
    logic [1:0] oERR_CODE, oRETRY_CNT;
    logic [2:0] oSTEP;

    int          total = 0, bad = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] rep_q[$];   // per TX: {count or EE=line error, b0, b1, b2}
    logic        bp = 1'b0;

    always #5 iCLK_50 = ~iCLK_50;

    ps2_mouse_init_seq #(
        .SAMPLE_RATE (8'd100),
        .ACK_TO_CYC  (50),
        .BAT_TO_CYC  (200),
        .MAX_RETRY   (3)
    ) dut (
        .iCLK_50    (iCLK_50),
        .iRST       (iRST),
        .iSTART     (iSTART),
        .iTX_RDY    (iTX_RDY),
        .oTX_REQ    (oTX_REQ),
        .oTX_DATA   (oTX_DATA),
        .iTX_DONE   (iTX_DONE),
        .iTX_ERR    (iTX_ERR),
        .iRX_VALID  (iRX_VALID),
        .iRX_DATA   (iRX_DATA),
        .oREADY     (oREADY),
        .oFAIL      (oFAIL),
        .oERR_CODE  (oERR_CODE),
        .oRETRY_CNT (oRETRY_CNT),
        .oSTEP      (oSTEP)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rep(input logic [7:0] n, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c);
        return {n, a, b, c};
    endfunction

    // expectations and replies for one fault-free pass
    task automatic push_clean();
        exp_q.push_back(8'hFF); rep_q.push_back(rep(8'd3, 8'hFA, 8'hAA, 8'h00));
        exp_q.push_back(8'hF3); rep_q.push_back(rep(8'd1, 8'hFA, 8'h00, 8'h00));
        exp_q.push_back(8'h64); rep_q.push_back(rep(8'd1, 8'hFA, 8'h00, 8'h00));
        exp_q.push_back(8'hF4); rep_q.push_back(rep(8'd1, 8'hFA, 8'h00, 8'h00));
    endtask

    task automatic pulse_start();
        @(negedge iCLK_50); #2 iSTART = 1'b1;
        @(negedge iCLK_50); #2 iSTART = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int maxc);
        bit hit = 1'b0;
        for (int i = 0; i < maxc && !hit; i++) begin
            @(negedge iCLK_50); #1;
            if (oREADY || oFAIL) hit = 1'b1;
        end
        if (!hit) chk({tag, "_wait"}, {31'd0, oREADY | oFAIL}, 32'd1);
    endtask

    task automatic chk_end(input string tag, input logic rdy, input logic fl,
                           input logic [1:0] err, input logic [1:0] rty);
        chk({tag, "_ready"}, {31'd0, oREADY}, {31'd0, rdy});
        chk({tag, "_fail"},  {31'd0, oFAIL},  {31'd0, fl});
        chk({tag, "_err"},   {30'd0, oERR_CODE},  {30'd0, err});
        chk({tag, "_retry"}, {30'd0, oRETRY_CNT}, {30'd0, rty});
        chk({tag, "_txleft"}, exp_q.size(), 32'd0);
    endtask

    // link + device model: TX takes 3 cycles, then replies spaced 3 cycles apart
    initial begin : link_model
        int          busy = 0, gap = 0;
        logic [7:0]  cur[$];
        logic [31:0] r;
        forever begin
            @(negedge iCLK_50);
            iTX_DONE = 1'b0; iTX_ERR = 1'b0; iRX_VALID = 1'b0;
            if (iRST || iSTART) begin
                busy = 0;
                cur.delete();
            end else if (oTX_REQ) begin
                chk("req_rdy", {31'd0, iTX_RDY}, 32'd1);
                if (exp_q.size() == 0) chk("tx_unexp", exp_q.size(), 32'd1);
                else chk("tx_byte", {24'd0, oTX_DATA}, {24'd0, exp_q.pop_front()});
                busy = 3;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    r = (rep_q.size() > 0) ? rep_q.pop_front() : 32'd0;
                    if (r[31:24] == 8'hEE) iTX_ERR = 1'b1;
                    else begin
                        iTX_DONE = 1'b1;
                        for (int k = 0; k < 3 && k < int'(r[31:24]); k++)
                            cur.push_back(r[23 - 8*k -: 8]);
                        gap = 2;
                    end
                end
            end else if (cur.size() > 0) begin
                gap--;
                if (gap == 0) begin
                    iRX_VALID = 1'b1;
                    iRX_DATA  = cur.pop_front();
                    gap = 3;
                end
            end
            iTX_RDY = !bp && (busy == 0);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int nreq;
        repeat (3) @(negedge iCLK_50);
        #1;
        chk("rst_req",   {31'd0, oTX_REQ}, 32'd0);
        chk("rst_data",  {24'd0, oTX_DATA}, 32'd0);
        chk("rst_ready", {31'd0, oREADY}, 32'd0);
        chk("rst_fail",  {31'd0, oFAIL}, 32'd0);
        chk("rst_err",   {30'd0, oERR_CODE}, 32'd0);
        chk("rst_retry", {30'd0, oRETRY_CNT}, 32'd0);
        chk("rst_step",  {29'd0, oSTEP}, 32'd0);
        #1 iRST = 1'b0;

        // clean init
        push_clean();
        pulse_start();
        wait_end("clean", 2000);
        chk_end("clean", 1'b1, 1'b0, 2'd0, 2'd0);
        chk("clean_step", {29'd0, oSTEP}, 32'd3);

        // one FE on F3, one line error on F4
        exp_q.push_back(8'hFF); rep_q.push_back(rep(8'd3, 8'hFA, 8'hAA, 8'h00));
        exp_q.push_back(8'hF3); rep_q.push_back(rep(8'd1, 8'hFE, 8'h00, 8'h00));
        exp_q.push_back(8'hF3); rep_q.push_back(rep(8'd1, 8'hFA, 8'h00, 8'h00));
        exp_q.push_back(8'h64); rep_q.push_back(rep(8'd1, 8'hFA, 8'h00, 8'h00));
        exp_q.push_back(8'hF4); rep_q.push_back(rep(8'hEE, 8'h00, 8'h00, 8'h00));
        exp_q.push_back(8'hF4); rep_q.push_back(rep(8'd1, 8'hFA, 8'h00, 8'h00));
        pulse_start();
        chk("start_clr_ready", {31'd0, oREADY}, 32'd0);
        wait_end("resend1", 2000);
        chk_end("resend1", 1'b1, 1'b0, 2'd0, 2'd0);

        // three FE in a row on F3 -> full restart
        exp_q.push_back(8'hFF); rep_q.push_back(rep(8'd3, 8'hFA, 8'hAA, 8'h00));
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'hF3); rep_q.push_back(rep(8'd1, 8'hFE, 8'h00, 8'h00));
        end
        push_clean();
        pulse_start();
        wait_end("resend3", 2000);
        chk_end("resend3", 1'b1, 1'b0, 2'd3, 2'd1);

        // F4 never acknowledged: four attempts then FAIL
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'hFF); rep_q.push_back(rep(8'd3, 8'hFA, 8'hAA, 8'h00));
            exp_q.push_back(8'hF3); rep_q.push_back(rep(8'd1, 8'hFA, 8'h00, 8'h00));
            exp_q.push_back(8'h64); rep_q.push_back(rep(8'd1, 8'hFA, 8'h00, 8'h00));
            exp_q.push_back(8'hF4); rep_q.push_back(rep(8'd0, 8'h00, 8'h00, 8'h00));
        end
        pulse_start();
        wait_end("tmo", 4000);
        chk_end("tmo", 1'b0, 1'b1, 2'd1, 2'd3);
        repeat (20) @(negedge iCLK_50);
        #1 chk("tmo_sticky", {31'd0, oFAIL}, 32'd1);

        // FC in place of AA
        exp_q.push_back(8'hFF); rep_q.push_back(rep(8'd2, 8'hFA, 8'hFC, 8'h00));
        push_clean();
        pulse_start();
        chk("start_clr_fail", {31'd0, oFAIL}, 32'd0);
        wait_end("devfc", 2000);
        chk_end("devfc", 1'b1, 1'b0, 2'd2, 2'd1);

        // abort while parked in WAIT_BAT after one FC restart
        exp_q.push_back(8'hFF); rep_q.push_back(rep(8'd1, 8'hFC, 8'h00, 8'h00));
        exp_q.push_back(8'hFF); rep_q.push_back(rep(8'd1, 8'hFA, 8'h00, 8'h00));
        pulse_start();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge iCLK_50);
        repeat (15) @(negedge iCLK_50);
        #1;
        chk("abort_pre_retry", {30'd0, oRETRY_CNT}, 32'd1);
        chk("abort_pre_err",   {30'd0, oERR_CODE}, 32'd2);
        chk("abort_pre_left",  exp_q.size(), 32'd0);
        push_clean();
        pulse_start();
        #1;
        chk("abort_retry", {30'd0, oRETRY_CNT}, 32'd0);
        chk("abort_err",   {30'd0, oERR_CODE}, 32'd0);
        chk("abort_step",  {29'd0, oSTEP}, 32'd0);
        wait_end("abort", 2000);
        chk_end("abort", 1'b1, 1'b0, 2'd0, 2'd0);

        // synchronous reset mid-sequence
        push_clean();
        pulse_start();
        for (int i = 0; i < 200 && exp_q.size() > 2; i++) @(negedge iCLK_50);
        @(negedge iCLK_50); #2 iRST = 1'b1;
        @(negedge iCLK_50); #1;
        chk("mrst_req",   {31'd0, oTX_REQ}, 32'd0);
        chk("mrst_data",  {24'd0, oTX_DATA}, 32'd0);
        chk("mrst_ready", {31'd0, oREADY}, 32'd0);
        chk("mrst_step",  {29'd0, oSTEP}, 32'd0);
        chk("mrst_retry", {30'd0, oRETRY_CNT}, 32'd0);
        #1 iRST = 1'b0;
        exp_q.delete();
        rep_q.delete();

        // link back-pressure: 1000 cycles with iTX_RDY low
        @(negedge iCLK_50); #2 bp = 1'b1;
        push_clean();
        pulse_start();
        nreq = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge iCLK_50); #1;
            if (oTX_REQ) nreq++;
        end
        chk("bp_noreq", nreq, 32'd0);
        chk("bp_fail",  {31'd0, oFAIL}, 32'd0);
        chk("bp_err",   {30'd0, oERR_CODE}, 32'd0);
        chk("bp_left",  exp_q.size(), 32'd4);
        @(negedge iCLK_50); #2 bp = 1'b0;
        @(negedge iCLK_50);
        @(negedge iCLK_50); #1;
        chk("bp_first", exp_q.size(), 32'd3);
        wait_end("bp", 2000);
        chk_end("bp", 1'b1, 1'b0, 2'd0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
